// File: rtl/gearbox_fifo_pkg.sv
// rtl/gearbox_fifo_pkg.sv - shared width/ratio derivation and direction type for gearbox_fifo
package gearbox_fifo_pkg;

    typedef enum logic [1:0] {
        W2N = 2'd0,
        N2W = 2'd1,
        EQ  = 2'd2
    } dir_e;

    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    function automatic int max_w(input int wr_w, input int rd_w);
        return (wr_w > rd_w) ? wr_w : rd_w;
    endfunction

    function automatic int min_w(input int wr_w, input int rd_w);
        return (wr_w < rd_w) ? wr_w : rd_w;
    endfunction

    function automatic int ratio(input int wr_w, input int rd_w);
        return max_w(wr_w, rd_w) / min_w(wr_w, rd_w);
    endfunction

    function automatic int log2_ratio(input int wr_w, input int rd_w);
        return clog2(ratio(wr_w, rd_w));
    endfunction

    // Level counts narrow units; one extra bit holds the completely-full value.
    function automatic int level_width(input int wr_w, input int rd_w, input int depth_w);
        return depth_w + log2_ratio(wr_w, rd_w) + 1;
    endfunction

    function automatic dir_e direction(input int wr_w, input int rd_w);
        if (wr_w > rd_w) return W2N;
        if (wr_w < rd_w) return N2W;
        return EQ;
    endfunction

endpackage

// File: rtl/gearbox_fifo_sdp_ram.sv
// rtl/gearbox_fifo_sdp_ram.sv - simple dual-port storage with registered read port
module gearbox_fifo_sdp_ram #(
    parameter int WIDTH = 128,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register only loads on a pop so the FIFO output holds between reads.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/gearbox_fifo.sv
// rtl/gearbox_fifo.sv - single-clock FIFO with power-of-two width gearbox in either direction
module gearbox_fifo
    import gearbox_fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH    = 128,
    parameter int RD_DATA_WIDTH    = 16,
    parameter int DEPTH_WIDTH      = 10,
    parameter int OUTPUT_REG       = 0,
    parameter int ALMOST_FULL_NUM  = 7680,
    parameter int ALMOST_EMPTY_NUM = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WR_DATA_WIDTH-1:0] wr_data,
    output logic                     wr_full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [RD_DATA_WIDTH-1:0] rd_data,
    output logic                     rd_valid,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [level_width(WR_DATA_WIDTH, RD_DATA_WIDTH, DEPTH_WIDTH)-1:0] level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int   MAX_W = max_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int   MIN_W = min_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int   RATIO = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int   LOG2R = log2_ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int   LW    = level_width(WR_DATA_WIDTH, RD_DATA_WIDTH, DEPTH_WIDTH);
    localparam int   D     = 1 << DEPTH_WIDTH;
    localparam dir_e DIR   = direction(WR_DATA_WIDTH, RD_DATA_WIDTH);

    localparam logic [LW-1:0] WR_UNITS = (DIR == W2N) ? LW'(RATIO) : LW'(1);
    localparam logic [LW-1:0] RD_UNITS = (DIR == N2W) ? LW'(RATIO) : LW'(1);
    localparam logic [LW-1:0] AF_LVL   = LW'(ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_LVL   = LW'(ALMOST_EMPTY_NUM);

    logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic                   overflow_q, overflow_d, underflow_q, underflow_d;
    logic                   pop_q, pop_d;

    logic                     full_s, empty_s;
    logic                     wr_acc, rd_acc, wr_adv, rd_adv;
    logic                     mem_we;
    logic [MAX_W-1:0]         mem_wdata, mem_rdata;
    logic [RD_DATA_WIDTH-1:0] rd_word;

    assign wr_acc = wr_en & ~full_s & ~flush;
    assign rd_acc = rd_en & ~empty_s & ~flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        pop_d       = rd_acc;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_adv) wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
            if (rd_adv) rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
            level_d     = level_q + (wr_acc ? WR_UNITS : '0) - (rd_acc ? RD_UNITS : '0);
            overflow_d  = overflow_q  | (wr_en & full_s);
            underflow_d = underflow_q | (rd_en & empty_s);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            pop_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            pop_q       <= pop_d;
        end
    end

    gearbox_fifo_sdp_ram #(
        .WIDTH (MAX_W),
        .AW    (DEPTH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    generate
        if (DIR == W2N) begin : g_w2n
            localparam logic [LOG2R-1:0] LAST_LANE = LOG2R'(RATIO - 1);
            localparam logic [LW-1:0]    FULL_THR  = LW'((D - 1) * RATIO);
            logic [LOG2R-1:0] rd_sub_q, rd_sub_d, lane_q, lane_d;

            // lane_q remembers which slice of the just-read entry belongs to this pop.
            always_comb begin
                rd_sub_d = rd_sub_q;
                lane_d   = lane_q;
                if (flush) begin
                    rd_sub_d = '0;
                end else if (rd_acc) begin
                    rd_sub_d = rd_sub_q + LOG2R'(1);
                    lane_d   = rd_sub_q;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_sub_q <= '0;
                    lane_q   <= '0;
                end else begin
                    rd_sub_q <= rd_sub_d;
                    lane_q   <= lane_d;
                end
            end

            always_comb begin
                rd_word = '0;
                for (int i = 0; i < RATIO; i++) begin
                    if (lane_q == LOG2R'(i)) rd_word = mem_rdata[i*MIN_W +: MIN_W];
                end
            end

            assign mem_we    = wr_acc;
            assign mem_wdata = wr_data;
            assign wr_adv    = wr_acc;
            assign rd_adv    = rd_acc && (rd_sub_q == LAST_LANE);
            assign full_s    = (level_q > FULL_THR);
            assign empty_s   = (level_q == '0);
        end else if (DIR == N2W) begin : g_n2w
            localparam int               ENT_W     = DEPTH_WIDTH + 1;
            localparam logic [LOG2R-1:0] LAST_LANE = LOG2R'(RATIO - 1);
            localparam logic [ENT_W-1:0] D_ENT     = ENT_W'(D);
            logic [MAX_W-1:0] asm_q, asm_d;
            logic [LOG2R-1:0] asm_cnt;
            logic [ENT_W-1:0] entries;

            // Level low bits are the assembly fill; high bits count committed entries.
            assign asm_cnt = level_q[LOG2R-1:0];
            assign entries = level_q[LW-1:LOG2R];

            always_comb begin
                asm_d = asm_q;
                for (int i = 0; i < RATIO; i++) begin
                    if (wr_acc && (asm_cnt == LOG2R'(i))) asm_d[i*MIN_W +: MIN_W] = wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) asm_q <= '0;
                else        asm_q <= asm_d;
            end

            assign mem_we    = wr_acc && (asm_cnt == LAST_LANE);
            assign mem_wdata = asm_d;
            assign wr_adv    = mem_we;
            assign rd_adv    = rd_acc;
            assign full_s    = (entries == D_ENT) && (asm_cnt == LAST_LANE);
            assign empty_s   = (entries == '0);
            assign rd_word   = mem_rdata;
        end else begin : g_eq
            localparam logic [LW-1:0] D_LVL = LW'(D);

            assign mem_we    = wr_acc;
            assign mem_wdata = wr_data;
            assign wr_adv    = wr_acc;
            assign rd_adv    = rd_acc;
            assign full_s    = (level_q == D_LVL);
            assign empty_s   = (level_q == '0);
            assign rd_word   = mem_rdata;
        end

        if (OUTPUT_REG != 0) begin : g_oreg
            logic [RD_DATA_WIDTH-1:0] out_q, out_d;
            logic                     vld_q, vld_d;

            always_comb begin
                vld_d = pop_q & ~flush;
                out_d = vld_d ? rd_word : out_q;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    out_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    out_q <= out_d;
                    vld_q <= vld_d;
                end
            end

            assign rd_data  = out_q;
            assign rd_valid = vld_q;
        end else begin : g_nreg
            assign rd_data  = rd_word;
            assign rd_valid = pop_q;
        end
    endgenerate

    assign wr_full      = full_s;
    assign rd_empty     = empty_s;
    assign level        = level_q;
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_gearbox_fifo.sv
// tb/tb_gearbox_fifo.sv - directed self-checking bench for gearbox_fifo
module tb_gearbox_fifo;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    // A: 128 -> 16, depth 1024
    logic a_flush, a_wr_en, a_rd_en, a_wr_full, a_af, a_rd_valid, a_rd_empty, a_ae, a_ovf, a_unf;
    logic [127:0] a_wr_data;
    logic [15:0]  a_rd_data;
    logic [13:0]  a_level;
    // B: 16 -> 128, depth 4
    logic b_flush, b_wr_en, b_rd_en, b_wr_full, b_af, b_rd_valid, b_rd_empty, b_ae, b_ovf, b_unf;
    logic [15:0]  b_wr_data;
    logic [127:0] b_rd_data;
    logic [5:0]   b_level;
    // C: 16 -> 16, depth 8, no output register
    logic c_flush, c_wr_en, c_rd_en, c_wr_full, c_af, c_rd_valid, c_rd_empty, c_ae, c_ovf, c_unf;
    logic [15:0]  c_wr_data, c_rd_data;
    logic [3:0]   c_level;
    // D: 16 -> 16, depth 8, output register
    logic d_flush, d_wr_en, d_rd_en, d_wr_full, d_af, d_rd_valid, d_rd_empty, d_ae, d_ovf, d_unf;
    logic [15:0]  d_wr_data, d_rd_data;
    logic [3:0]   d_level;

    gearbox_fifo #(.WR_DATA_WIDTH(128), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(10), .OUTPUT_REG(0),
                   .ALMOST_FULL_NUM(7680), .ALMOST_EMPTY_NUM(512)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .wr_full(a_wr_full), .almost_full(a_af), .rd_en(a_rd_en), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .rd_empty(a_rd_empty), .almost_empty(a_ae), .level(a_level),
        .overflow(a_ovf), .underflow(a_unf));

    gearbox_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(128), .DEPTH_WIDTH(2), .OUTPUT_REG(0),
                   .ALMOST_FULL_NUM(24), .ALMOST_EMPTY_NUM(2)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .wr_full(b_wr_full), .almost_full(b_af), .rd_en(b_rd_en), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .rd_empty(b_rd_empty), .almost_empty(b_ae), .level(b_level),
        .overflow(b_ovf), .underflow(b_unf));

    gearbox_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(3), .OUTPUT_REG(0),
                   .ALMOST_FULL_NUM(6), .ALMOST_EMPTY_NUM(1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr_en), .wr_data(c_wr_data),
        .wr_full(c_wr_full), .almost_full(c_af), .rd_en(c_rd_en), .rd_data(c_rd_data),
        .rd_valid(c_rd_valid), .rd_empty(c_rd_empty), .almost_empty(c_ae), .level(c_level),
        .overflow(c_ovf), .underflow(c_unf));

    gearbox_fifo #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(3), .OUTPUT_REG(1),
                   .ALMOST_FULL_NUM(6), .ALMOST_EMPTY_NUM(1)) u_d (
        .clk(clk), .rst_n(rst_n), .flush(d_flush), .wr_en(d_wr_en), .wr_data(d_wr_data),
        .wr_full(d_wr_full), .almost_full(d_af), .rd_en(d_rd_en), .rd_data(d_rd_data),
        .rd_valid(d_rd_valid), .rd_empty(d_rd_empty), .almost_empty(d_ae), .level(d_level),
        .overflow(d_ovf), .underflow(d_unf));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] fill_word(input int idx);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(idx * 8 + j);
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (a_rd_empty !== 1'b1) begin errors++; $display("FAIL reset_rd_empty: got %b expected 1", a_rd_empty); end
        checks++; if (a_ae !== 1'b1) begin errors++; $display("FAIL reset_almost_empty: got %b expected 1", a_ae); end
        checks++; if (a_level !== 14'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", a_level); end
        checks++; if (a_wr_full !== 1'b0) begin errors++; $display("FAIL reset_wr_full: got %b expected 0", a_wr_full); end
        checks++; if (a_af !== 1'b0) begin errors++; $display("FAIL reset_almost_full: got %b expected 0", a_af); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", a_rd_valid); end
        checks++; if (a_rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0000", a_rd_data); end
        checks++; if ({a_ovf, a_unf} !== 2'b00) begin errors++; $display("FAIL reset_sticky: got %b expected 00", {a_ovf, a_unf}); end
        checks++; if (b_rd_empty !== 1'b1) begin errors++; $display("FAIL reset_n2w_rd_empty: got %b expected 1", b_rd_empty); end
        checks++; if (d_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_oreg_rd_valid: got %b expected 0", d_rd_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_w2n_order();
        a_wr_data = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        a_wr_en = 1'b1;
        step();
        a_wr_en = 1'b0;
        checks++; if (a_level !== 14'd8) begin errors++; $display("FAIL w2n_level_after_write: got %0d expected 8", a_level); end
        checks++; if (a_rd_empty !== 1'b0) begin errors++; $display("FAIL w2n_not_empty: got %b expected 0", a_rd_empty); end
        for (int i = 0; i < 8; i++) begin
            a_rd_en = 1'b1;
            step();
            checks++; if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL w2n_rd_valid[%0d]: got %b expected 1", i, a_rd_valid); end
            checks++; if (a_rd_data !== 16'(i)) begin errors++; $display("FAIL w2n_rd_data[%0d]: got %h expected %h", i, a_rd_data, 16'(i)); end
            checks++; if (a_level !== 14'(7 - i)) begin errors++; $display("FAIL w2n_level[%0d]: got %0d expected %0d", i, a_level, 7 - i); end
        end
        a_rd_en = 1'b0;
        step();
        checks++; if (a_rd_empty !== 1'b1) begin errors++; $display("FAIL w2n_empty_after_drain: got %b expected 1", a_rd_empty); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL w2n_valid_drop: got %b expected 0", a_rd_valid); end
        checks++; if (a_rd_data !== 16'h0007) begin errors++; $display("FAIL w2n_data_hold: got %h expected 0007", a_rd_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 1024; i++) begin
            a_wr_data = fill_word(i);
            a_wr_en = 1'b1;
            step();
            if (i == 63) begin
                checks++; if (a_ae !== 1'b1) begin errors++; $display("FAIL fill_ae_at_512: got %b expected 1", a_ae); end
            end
            if (i == 64) begin
                checks++; if (a_ae !== 1'b0) begin errors++; $display("FAIL fill_ae_at_520: got %b expected 0", a_ae); end
            end
            if (i == 958) begin
                checks++; if (a_af !== 1'b0) begin errors++; $display("FAIL fill_af_at_7672: got %b expected 0", a_af); end
            end
            if (i == 959) begin
                checks++; if (a_af !== 1'b1) begin errors++; $display("FAIL fill_af_at_7680: got %b expected 1", a_af); end
            end
            if (i == 1022) begin
                checks++; if (a_wr_full !== 1'b0) begin errors++; $display("FAIL fill_not_full_1023: got %b expected 0", a_wr_full); end
            end
        end
        checks++; if (a_wr_full !== 1'b1) begin errors++; $display("FAIL fill_wr_full: got %b expected 1", a_wr_full); end
        checks++; if (a_level !== 14'd8192) begin errors++; $display("FAIL fill_level: got %0d expected 8192", a_level); end
        a_wr_data = fill_word(2000);
        step();
        a_wr_en = 1'b0;
        checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL fill_overflow: got %b expected 1", a_ovf); end
        checks++; if (a_level !== 14'd8192) begin errors++; $display("FAIL fill_level_after_ovf: got %0d expected 8192", a_level); end
        for (int j = 0; j < 8; j++) begin
            a_rd_en = 1'b1;
            step();
            checks++; if (a_rd_data !== 16'(j)) begin errors++; $display("FAIL fill_rd_data[%0d]: got %h expected %h", j, a_rd_data, 16'(j)); end
            if (j == 0) begin
                checks++; if (a_wr_full !== 1'b1) begin errors++; $display("FAIL fill_full_after_1_read: got %b expected 1", a_wr_full); end
            end
        end
        a_rd_en = 1'b0;
        checks++; if (a_wr_full !== 1'b0) begin errors++; $display("FAIL fill_full_after_8_reads: got %b expected 0", a_wr_full); end
        checks++; if (a_level !== 14'd8184) begin errors++; $display("FAIL fill_level_after_reads: got %0d expected 8184", a_level); end
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        checks++; if (a_level !== 14'd0) begin errors++; $display("FAIL fill_flush_level: got %0d expected 0", a_level); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL fill_flush_overflow: got %b expected 0", a_ovf); end
        checks++; if (a_rd_data !== 16'h0007) begin errors++; $display("FAIL fill_flush_data_hold: got %h expected 0007", a_rd_data); end
    endtask

    task automatic test_underflow();
        a_rd_en = 1'b1;
        step();
        a_rd_en = 1'b0;
        checks++; if (a_unf !== 1'b1) begin errors++; $display("FAIL underflow_flag: got %b expected 1", a_unf); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_rd_valid: got %b expected 0", a_rd_valid); end
        checks++; if (a_level !== 14'd0) begin errors++; $display("FAIL underflow_level: got %0d expected 0", a_level); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            a_wr_data = fill_word(i + 50);
            a_wr_en = 1'b1;
            step();
        end
        a_wr_en = 1'b0;
        checks++; if (a_level !== 14'd40) begin errors++; $display("FAIL flush_setup_level: got %0d expected 40", a_level); end
        a_flush = 1'b1;
        a_wr_en = 1'b1;
        a_rd_en = 1'b1;
        step();
        a_flush = 1'b0;
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        checks++; if (a_level !== 14'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", a_level); end
        checks++; if (a_rd_empty !== 1'b1) begin errors++; $display("FAIL flush_rd_empty: got %b expected 1", a_rd_empty); end
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid: got %b expected 0", a_rd_valid); end
        checks++; if ({a_ovf, a_unf} !== 2'b00) begin errors++; $display("FAIL flush_sticky: got %b expected 00", {a_ovf, a_unf}); end
        step();
        checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid_late: got %b expected 0", a_rd_valid); end
    endtask

    task automatic test_n2w();
        for (int i = 0; i < 8; i++) begin
            b_wr_data = 16'(i);
            b_wr_en = 1'b1;
            step();
            if (i == 6) begin
                checks++; if (b_level !== 6'd7) begin errors++; $display("FAIL n2w_level_7: got %0d expected 7", b_level); end
                checks++; if (b_rd_empty !== 1'b1) begin errors++; $display("FAIL n2w_partial_empty: got %b expected 1", b_rd_empty); end
            end
        end
        b_wr_en = 1'b0;
        checks++; if (b_rd_empty !== 1'b0) begin errors++; $display("FAIL n2w_committed: got %b expected 0", b_rd_empty); end
        b_rd_en = 1'b1;
        step();
        b_rd_en = 1'b0;
        checks++; if (b_rd_valid !== 1'b1) begin errors++; $display("FAIL n2w_rd_valid: got %b expected 1", b_rd_valid); end
        checks++; if (b_rd_data !== 128'h0007_0006_0005_0004_0003_0002_0001_0000) begin
            errors++; $display("FAIL n2w_rd_data: got %h expected 00070006000500040003000200010000", b_rd_data);
        end
        checks++; if (b_level !== 6'd0) begin errors++; $display("FAIL n2w_level_0: got %0d expected 0", b_level); end
        for (int i = 0; i < 39; i++) begin
            b_wr_data = 16'(i + 100);
            b_wr_en = 1'b1;
            step();
            if (i == 37) begin
                checks++; if (b_wr_full !== 1'b0) begin errors++; $display("FAIL n2w_not_full_38: got %b expected 0", b_wr_full); end
            end
        end
        checks++; if (b_wr_full !== 1'b1) begin errors++; $display("FAIL n2w_full_39: got %b expected 1", b_wr_full); end
        checks++; if (b_level !== 6'd39) begin errors++; $display("FAIL n2w_full_level: got %0d expected 39", b_level); end
        step();
        b_wr_en = 1'b0;
        checks++; if (b_ovf !== 1'b1) begin errors++; $display("FAIL n2w_overflow: got %b expected 1", b_ovf); end
        checks++; if (b_level !== 6'd39) begin errors++; $display("FAIL n2w_level_after_ovf: got %0d expected 39", b_level); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            c_wr_data = 16'(100 + i);
            d_wr_data = 16'(100 + i);
            c_wr_en = 1'b1;
            d_wr_en = 1'b1;
            step();
        end
        checks++; if (c_level !== 4'd5) begin errors++; $display("FAIL b2b_c_prefill: got %0d expected 5", c_level); end
        checks++; if (d_level !== 4'd5) begin errors++; $display("FAIL b2b_d_prefill: got %0d expected 5", d_level); end
        for (int k = 0; k < 100; k++) begin
            c_wr_data = 16'(105 + k);
            d_wr_data = 16'(105 + k);
            c_rd_en = 1'b1;
            d_rd_en = 1'b1;
            step();
            checks++; if (c_level !== 4'd5) begin errors++; $display("FAIL b2b_c_level[%0d]: got %0d expected 5", k, c_level); end
            checks++; if (d_level !== 4'd5) begin errors++; $display("FAIL b2b_d_level[%0d]: got %0d expected 5", k, d_level); end
            checks++; if ({c_rd_valid, c_rd_data} !== {1'b1, 16'(100 + k)}) begin
                errors++; $display("FAIL b2b_c_data[%0d]: got %b/%0d expected 1/%0d", k, c_rd_valid, c_rd_data, 100 + k);
            end
            if (k == 0) begin
                checks++; if (d_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_d_latency: got %b expected 0", d_rd_valid); end
            end else begin
                checks++; if ({d_rd_valid, d_rd_data} !== {1'b1, 16'(99 + k)}) begin
                    errors++; $display("FAIL b2b_d_data[%0d]: got %b/%0d expected 1/%0d", k, d_rd_valid, d_rd_data, 99 + k);
                end
            end
        end
        c_wr_en = 1'b0;
        d_wr_en = 1'b0;
        c_rd_en = 1'b0;
        d_rd_en = 1'b0;
        step();
        checks++; if ({c_rd_valid, c_rd_data} !== {1'b0, 16'd199}) begin
            errors++; $display("FAIL b2b_c_tail: got %b/%0d expected 0/199", c_rd_valid, c_rd_data);
        end
        checks++; if ({d_rd_valid, d_rd_data} !== {1'b1, 16'd199}) begin
            errors++; $display("FAIL b2b_d_tail: got %b/%0d expected 1/199", d_rd_valid, d_rd_data);
        end
        step();
        checks++; if (d_rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_d_valid_drop: got %b expected 0", d_rd_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a_flush = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
        b_flush = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
        c_flush = 1'b0; c_wr_en = 1'b0; c_rd_en = 1'b0; c_wr_data = '0;
        d_flush = 1'b0; d_wr_en = 1'b0; d_rd_en = 1'b0; d_wr_data = '0;
        test_reset();
        test_w2n_order();
        test_fill();
        test_underflow();
        test_flush();
        test_n2w();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
